// File: rtl/regfile_pkg.sv
// Shared types and constants for the regfile_mc register file.
// The preload constants apply only when REGFILE_DEBUG_PRELOAD_EN is defined.
package regfile_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LUI  = 2'd1,
        WB_LINK = 2'd2
    } wb_sel_e;

    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2,
        LD_D = 2'd3
    } ld_size_e;

    localparam int PRELOAD_N = 3;
    localparam int PRELOAD_ADDR [PRELOAD_N] = '{5, 6, 8};
    localparam int PRELOAD_VAL  [PRELOAD_N] = '{5, 7, 12};

endpackage

// File: rtl/regfile_mc_load_ext.sv
// Combinational load-data sign/zero extension from byte, half, word or double to XLEN.
// The value is moved to the top of the word and shifted back down, so one path covers every size.
module rf_load_ext
    import regfile_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] raw_i,
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    output logic [XLEN-1:0] ext_o
);

    logic [6:0]      sh;
    logic [XLEN-1:0] up;

    // NOTE: every always_comb output is given a default first, so no path can infer a latch.
    always_comb begin
        sh = 7'd0;
        case (ld_size_e'(size_i))
            LD_B:    sh = 7'(XLEN - 8);
            LD_H:    sh = 7'(XLEN - 16);
            LD_W:    sh = 7'(XLEN - 32);
            default: sh = 7'd0;  // a double on XLEN=32 is the same as a word
        endcase
        up    = raw_i << sh;
        ext_o = unsigned_i ? (up >> sh) : XLEN'($signed(up) >>> sh);
    end

endmodule

// File: rtl/regfile_mc.sv
// RV32I/E integer register file with a write-port arbiter, a load skid buffer and a pending-load scoreboard.
// Optional: REGFILE_DEBUG_PRELOAD_EN seeds x5/x6/x8 at reset for bring-up without a loader.
module regfile_mc
    import regfile_pkg::*;
#(
    parameter int  XLEN   = 32,
    parameter int  NREGS  = 32,
    parameter int  BYPASS = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    output logic             rs1_busy,
    output logic             rs2_busy,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_rd,
    input  logic [1:0]       wb_sel,
    input  logic [XLEN-1:0]  wb_alu_data,
    input  logic [XLEN-1:0]  wb_imm_data,
    input  logic [XLEN-1:0]  wb_link_data,
    input  logic             ld_issue_valid,
    input  logic [AW-1:0]    ld_issue_rd,
    output logic             ld_issue_ready,
    input  logic             ld_rsp_valid,
    output logic             ld_rsp_ready,
    input  logic [AW-1:0]    ld_rsp_rd,
    input  logic [XLEN-1:0]  ld_rsp_data,
    input  logic [1:0]       ld_rsp_size,
    input  logic             ld_rsp_unsigned,
    output logic [NREGS-1:0] busy_vec
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic             skid_valid_q, skid_valid_d;
    logic [AW-1:0]    skid_rd_q, skid_rd_d;
    logic [XLEN-1:0]  skid_data_q, skid_data_d;

    logic [XLEN-1:0]  wb_data, ext_data, w_data;
    logic [AW-1:0]    w_rd;
    logic             w_en, w_is_load, rsp_acc, issue_fire;
    logic             rs1_hit, rs2_hit;

    rf_load_ext #(.XLEN(XLEN)) u_ext (
        .raw_i      (ld_rsp_data),
        .size_i     (ld_rsp_size),
        .unsigned_i (ld_rsp_unsigned),
        .ext_o      (ext_data)
    );

    always_comb begin
        case (wb_sel_e'(wb_sel))
            WB_LUI:  wb_data = wb_imm_data;
            WB_LINK: wb_data = wb_link_data;
            default: wb_data = wb_alu_data;
        endcase
    end

    assign ld_rsp_ready   = !skid_valid_q;
    assign rsp_acc        = ld_rsp_valid && ld_rsp_ready;
    assign ld_issue_ready = !busy_q[ld_issue_rd];
    assign issue_fire     = ld_issue_valid && ld_issue_ready;
    assign busy_vec       = busy_q;

    // Write port priority: core write-back, then the parked response, then a fresh response.
    always_comb begin
        w_en         = 1'b0;
        w_is_load    = 1'b0;
        w_rd         = '0;
        w_data       = '0;
        skid_valid_d = skid_valid_q;
        skid_rd_d    = skid_rd_q;
        skid_data_d  = skid_data_q;
        if (wb_valid) begin
            w_en   = 1'b1;
            w_rd   = wb_rd;
            w_data = wb_data;
            if (rsp_acc) begin
                skid_valid_d = 1'b1;
                skid_rd_d    = ld_rsp_rd;
                skid_data_d  = ext_data;
            end
        end else if (skid_valid_q) begin
            w_en         = 1'b1;
            w_is_load    = 1'b1;
            w_rd         = skid_rd_q;
            w_data       = skid_data_q;
            skid_valid_d = 1'b0;
        end else if (rsp_acc) begin
            w_en      = 1'b1;
            w_is_load = 1'b1;
            w_rd      = ld_rsp_rd;
            w_data    = ext_data;
        end
    end

    // Busy clears only when the load data lands in the array, not while it sits in the skid.
    always_comb begin
        busy_d = busy_q;
        if (w_en && w_is_load) busy_d[w_rd] = 1'b0;
        if (issue_fire) busy_d[ld_issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    assign rs1_hit  = (BYPASS != 0) && w_en && (w_rd != '0) && (rs1_addr == w_rd);
    assign rs2_hit  = (BYPASS != 0) && w_en && (w_rd != '0) && (rs2_addr == w_rd);
    assign rs1_data = rs1_hit ? w_data : regs_q[rs1_addr];
    assign rs2_data = rs2_hit ? w_data : regs_q[rs2_addr];
    assign rs1_busy = busy_q[rs1_addr] && !rs1_hit;
    assign rs2_busy = busy_q[rs2_addr] && !rs2_hit;

    // NOTE: state is updated with non-blocking assignments, so every block reads pre-edge values.
    // NOTE: the array is deliberately reset as flops; software relies on a zeroed register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
`ifdef REGFILE_DEBUG_PRELOAD_EN
            for (int i = 0; i < PRELOAD_N; i++) regs_q[PRELOAD_ADDR[i]] <= XLEN'(PRELOAD_VAL[i]);
`endif
            busy_q       <= '0;
            skid_valid_q <= 1'b0;
            skid_rd_q    <= '0;
            skid_data_q  <= '0;
        end else begin
            if (w_en && (w_rd != '0)) regs_q[w_rd] <= w_data;
            busy_q       <= busy_d;
            skid_valid_q <= skid_valid_d;
            skid_rd_q    <= skid_rd_d;
            skid_data_q  <= skid_data_d;
        end
    end

    a_wb_not_busy: assert property (@(posedge clk) disable iff (reset)
        (wb_valid && (wb_rd != '0)) |-> !busy_q[wb_rd]);
    a_rsp_busy: assert property (@(posedge clk) disable iff (reset)
        (rsp_acc && (ld_rsp_rd != '0)) |-> busy_q[ld_rsp_rd]);

endmodule

// File: tb/tb_regfile_mc.sv
// Self-checking bench for regfile_mc: directed scenarios plus randomized traffic against a behavioural model.
// Expected reset contents follow REGFILE_DEBUG_PRELOAD_EN when it is defined.
module tb_regfile_mc;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [AW-1:0]    rs1_addr = '0, rs2_addr = '0;
    logic [XLEN-1:0]  rs1_data, rs2_data;
    logic             rs1_busy, rs2_busy;
    logic             wb_valid = 1'b0;
    logic [AW-1:0]    wb_rd = '0;
    logic [1:0]       wb_sel = '0;
    logic [XLEN-1:0]  wb_alu_data = '0, wb_imm_data = '0, wb_link_data = '0;
    logic             ld_issue_valid = 1'b0;
    logic [AW-1:0]    ld_issue_rd = '0;
    logic             ld_issue_ready;
    logic             ld_rsp_valid = 1'b0;
    logic             ld_rsp_ready;
    logic [AW-1:0]    ld_rsp_rd = '0;
    logic [XLEN-1:0]  ld_rsp_data = '0;
    logic [1:0]       ld_rsp_size = '0;
    logic             ld_rsp_unsigned = 1'b0;
    logic [NREGS-1:0] busy_vec;

    always #5 clk = ~clk;

    regfile_mc dut (
        .clk(clk), .reset(reset),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_sel(wb_sel),
        .wb_alu_data(wb_alu_data), .wb_imm_data(wb_imm_data), .wb_link_data(wb_link_data),
        .ld_issue_valid(ld_issue_valid), .ld_issue_rd(ld_issue_rd), .ld_issue_ready(ld_issue_ready),
        .ld_rsp_valid(ld_rsp_valid), .ld_rsp_ready(ld_rsp_ready), .ld_rsp_rd(ld_rsp_rd),
        .ld_rsp_data(ld_rsp_data), .ld_rsp_size(ld_rsp_size), .ld_rsp_unsigned(ld_rsp_unsigned),
        .busy_vec(busy_vec)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: architectural registers, pending-load set, parked response list.
    typedef struct { int rd; logic [31:0] data; } parked_t;
    logic [31:0] m_regs [NREGS];
    bit          m_busy [NREGS];
    parked_t     m_park [$];
    int          outst  [$];

    function automatic logic [31:0] m_ext(logic [31:0] raw, logic [1:0] size, logic uns);
        int          w    = (size == 2'd0) ? 8 : (size == 2'd1) ? 16 : 32;
        logic [31:0] mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        logic [31:0] v    = raw & mask;
        if (!uns && w < 32 && v[w-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] m_wb_data();
        if (wb_sel == 2'd1) return wb_imm_data;
        if (wb_sel == 2'd2) return wb_link_data;
        return wb_alu_data;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = 32'd0;
            m_busy[i] = 1'b0;
        end
`ifdef REGFILE_DEBUG_PRELOAD_EN
        m_regs[5] = 32'd5;
        m_regs[6] = 32'd7;
        m_regs[8] = 32'd12;
`endif
        m_park.delete();
        outst.delete();
    endtask

    // Which write lands this cycle, worked out from the current inputs and model state.
    task automatic m_winner(output bit has, output int rd, output logic [31:0] data, output bit is_ld);
        has = 1'b0; rd = 0; data = 32'd0; is_ld = 1'b0;
        if (wb_valid) begin
            has = 1'b1; rd = int'(wb_rd); data = m_wb_data();
        end else if (m_park.size() != 0) begin
            has = 1'b1; rd = m_park[0].rd; data = m_park[0].data; is_ld = 1'b1;
        end else if (ld_rsp_valid) begin
            has = 1'b1; rd = int'(ld_rsp_rd); is_ld = 1'b1;
            data = m_ext(ld_rsp_data, ld_rsp_size, ld_rsp_unsigned);
        end
    endtask

    task automatic check_outputs();
        bit has, is_ld; int rd; logic [31:0] data;
        logic [NREGS-1:0] bv;
        bit h1, h2;
        m_winner(has, rd, data, is_ld);
        h1 = has && rd != 0 && int'(rs1_addr) == rd;
        h2 = has && rd != 0 && int'(rs2_addr) == rd;
        for (int i = 0; i < NREGS; i++) bv[i] = m_busy[i];
        check("rs1_data", 64'(rs1_data), 64'(h1 ? data : m_regs[rs1_addr]));
        check("rs2_data", 64'(rs2_data), 64'(h2 ? data : m_regs[rs2_addr]));
        check("rs1_busy", 64'(rs1_busy), 64'(m_busy[rs1_addr] && !h1));
        check("rs2_busy", 64'(rs2_busy), 64'(m_busy[rs2_addr] && !h2));
        check("busy_vec", 64'(busy_vec), 64'(bv));
        check("ld_rsp_ready", 64'(ld_rsp_ready), 64'(m_park.size() == 0));
        check("ld_issue_ready", 64'(ld_issue_ready), 64'(!m_busy[ld_issue_rd]));
    endtask

    task automatic m_update();
        bit has, is_ld; int rd; logic [31:0] data;
        bit acc  = ld_rsp_valid && (m_park.size() == 0);
        bit fire = ld_issue_valid && !m_busy[ld_issue_rd] && ld_issue_rd != '0;
        m_winner(has, rd, data, is_ld);
        if (wb_valid && acc)
            m_park.push_back('{int'(ld_rsp_rd), m_ext(ld_rsp_data, ld_rsp_size, ld_rsp_unsigned)});
        else if (is_ld && m_park.size() != 0 && !wb_valid)
            void'(m_park.pop_front());
        if (has && rd != 0) m_regs[rd] = data;
        if (has && is_ld) m_busy[rd] = 1'b0;
        if (acc) begin
            for (int i = 0; i < outst.size(); i++)
                if (outst[i] == int'(ld_rsp_rd)) begin outst.delete(i); break; end
        end
        if (fire) begin
            m_busy[ld_issue_rd] = 1'b1;
            outst.push_back(int'(ld_issue_rd));
        end
    endtask

    // Called at a falling edge with inputs driven; checks, clocks, returns at the next falling edge.
    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        m_update();
        @(negedge clk);
    endtask

    task automatic idle();
        wb_valid = 1'b0; ld_issue_valid = 1'b0; ld_rsp_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        @(posedge clk);
        m_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drive_wb(input int rd, input logic [1:0] sel, input logic [31:0] d);
        wb_valid = 1'b1; wb_rd = AW'(rd); wb_sel = sel;
        wb_alu_data = d; wb_imm_data = d ^ 32'h5A5A_0000; wb_link_data = d ^ 32'h0000_A5A5;
        if (sel == 2'd1) wb_imm_data = d;
        if (sel == 2'd2) wb_link_data = d;
    endtask

    task automatic drive_rsp(input int rd, input logic [31:0] d, input logic [1:0] sz, input logic uns);
        ld_rsp_valid = 1'b1; ld_rsp_rd = AW'(rd); ld_rsp_data = d;
        ld_rsp_size = sz; ld_rsp_unsigned = uns;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp5, exp6, exp8;
`ifdef REGFILE_DEBUG_PRELOAD_EN
        exp5 = 32'd5; exp6 = 32'd7; exp8 = 32'd12;
`else
        exp5 = 32'd0; exp6 = 32'd0; exp8 = 32'd0;
`endif
        @(negedge clk);
        do_reset();

        // Reset state
        rs1_addr = 5'd5; rs2_addr = 5'd6; #1;
        check("reset_x5", 64'(rs1_data), 64'(exp5));
        check("reset_x6", 64'(rs2_data), 64'(exp6));
        check("reset_rdy", 64'(ld_rsp_ready), 64'd1);
        check("reset_busy", 64'(busy_vec), 64'd0);
        step();
        rs1_addr = 5'd8; rs2_addr = 5'd0; #1;
        check("reset_x8", 64'(rs1_data), 64'(exp8));
        check("reset_x0", 64'(rs2_data), 64'd0);
        step();

        // LUI write with same-cycle bypass, then a dropped write to x0
        drive_wb(3, 2'd1, 32'h1234_5000); rs1_addr = 5'd3; #1;
        check("bypass_x3", 64'(rs1_data), 64'h1234_5000);
        step();
        drive_wb(0, 2'd0, 32'hDEAD_BEEF); rs2_addr = 5'd0; #1;
        check("x0_write_cycle", 64'(rs2_data), 64'd0);
        step();
        idle(); #1;
        check("x0_after", 64'(rs2_data), 64'd0);
        check("x3_array", 64'(rs1_data), 64'h1234_5000);
        step();
        drive_wb(4, 2'd2, 32'h0000_0104); step();
        idle(); rs1_addr = 5'd4; step();

        // Load to x7: byte signed, then half unsigned
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd7; step();
        idle(); #1;
        check("x7_busy_set", 64'(busy_vec[7]), 64'd1);
        check("x7_issue_blocked", 64'(ld_issue_ready), 64'd0);
        step();
        drive_rsp(7, 32'h0000_00F0, 2'd0, 1'b0); step();
        idle(); rs1_addr = 5'd7; #1;
        check("x7_byte_signed", 64'(rs1_data), 64'hFFFF_FFF0);
        check("x7_busy_clear", 64'(busy_vec[7]), 64'd0);
        step();
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd7; step();
        idle(); drive_rsp(7, 32'h0000_00F0, 2'd1, 1'b1); step();
        idle(); #1;
        check("x7_half_unsigned", 64'(rs1_data), 64'h0000_00F0);
        step();

        // Collision, sustained write-back with a second response stalled, then drain
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd7; step();
        ld_issue_rd = 5'd11; step();
        idle(); drive_rsp(7, 32'h0000_0080, 2'd0, 1'b1); drive_wb(9, 2'd0, 32'h0000_ABCD); step();
        for (int k = 0; k < 5; k++) begin
            drive_wb(12 + k, 2'd0, 32'h100 + k);
            drive_rsp(11, 32'h0000_8001, 2'd1, 1'b0); #1;
            check("stall_rsp_ready", 64'(ld_rsp_ready), 64'd0);
            check("stall_x7_busy", 64'(busy_vec[7]), 64'd1);
            step();
        end
        wb_valid = 1'b0; rs1_addr = 5'd7; rs2_addr = 5'd9; #1;
        check("drain_x7_bypass", 64'(rs1_data), 64'h0000_0080);
        check("drain_x7_rs1busy", 64'(rs1_busy), 64'd0);
        check("x9_written", 64'(rs2_data), 64'h0000_ABCD);
        step();
        #1;
        check("rdy_back", 64'(ld_rsp_ready), 64'd1);
        step();
        idle(); rs2_addr = 5'd11; #1;
        check("x7_after_drain", 64'(rs1_data), 64'h0000_0080);
        check("x11_not_lost", 64'(rs2_data), 64'hFFFF_8001);
        check("busy_all_clear", 64'(busy_vec), 64'd0);
        step();

        // Reset while the skid is full and x7 is busy
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd7; step();
        idle(); drive_rsp(7, 32'h0000_0055, 2'd2, 1'b0); drive_wb(9, 2'd0, 32'h0000_0999); step();
        idle(); #1;
        check("pre_reset_skid_full", 64'(ld_rsp_ready), 64'd0);
        do_reset();
        rs1_addr = 5'd7; #1;
        check("post_reset_busy", 64'(busy_vec), 64'd0);
        check("post_reset_rdy", 64'(ld_rsp_ready), 64'd1);
        step();
        step();
        #1;
        check("post_reset_x7", 64'(rs1_data), 64'd0);
        step();

        // Randomized traffic that respects the handshake rules
        for (int c = 0; c < 400; c++) begin
            int r;
            rs1_addr = AW'($urandom_range(0, NREGS - 1));
            rs2_addr = AW'($urandom_range(0, NREGS - 1));
            r = $urandom_range(0, NREGS - 1);
            wb_valid = ($urandom_range(0, 1) == 1) && !m_busy[r];
            wb_rd = AW'(r); wb_sel = 2'($urandom_range(0, 3));
            wb_alu_data = $urandom; wb_imm_data = $urandom; wb_link_data = $urandom;
            ld_issue_valid = ($urandom_range(0, 2) == 0);
            ld_issue_rd = AW'($urandom_range(0, NREGS - 1));
            ld_rsp_valid = 1'b0;
            if (outst.size() != 0 && $urandom_range(0, 1) == 1) begin
                ld_rsp_valid = 1'b1;
                ld_rsp_rd = AW'(outst[$urandom_range(0, outst.size() - 1)]);
            end
            ld_rsp_data = $urandom;
            ld_rsp_size = 2'($urandom_range(0, 3));
            ld_rsp_unsigned = 1'($urandom_range(0, 1));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
